// File: rtl/fabric3_pkg.sv
// Shared constants, clog2 helper and master FSM encoding for fabric3.
package fabric3_pkg;

  localparam int NMASTERS_DEF     = 2;
  localparam int NSLAVES_DEF      = 5;
  localparam int PORTNO_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OWN  = 2'd2
  } mst_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int midx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fabric3_arbiter.sv
// Per-slave arbiter: round-robin when FABRIC3_RR_ARB_EN is defined,
// otherwise fixed priority with the lowest index winning.
module fabric3_arbiter
  import fabric3_pkg::*;
#(
  parameter int N = 2,
  parameter int W = midx_w(N)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);

`ifdef FABRIC3_RR_ARB_EN
  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    logic hit;
    int   j;
    hit   = 1'b0;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    ptr_d = ptr_q;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!hit && req_i[j]) begin
        hit      = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = W'(j);
        ptr_d    = (j == N - 1) ? '0 : W'(j + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ nrst;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/fabric3_control.sv
// Fabric ownership control: per-master IDLE/WAIT/OWN FSM, zero-latency
// per-slave arbitration. FABRIC3_RR_ARB_EN selects round-robin.
module fabric3_control
  import fabric3_pkg::*;
#(
  parameter  int NMASTERS     = NMASTERS_DEF,
  parameter  int NSLAVES      = NSLAVES_DEF,
  parameter  int PORTNO_WIDTH = PORTNO_WIDTH_DEF,
  localparam int MIDX_W       = midx_w(NMASTERS),
  localparam int PW           = PORTNO_WIDTH
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NMASTERS-1:0]       i_act,
  input  logic [NMASTERS-1:0]       i_done,
  input  logic [NMASTERS*PW-1:0]    i_portno,
  output logic [NMASTERS-1:0]       o_grant,
  output logic [NMASTERS*PW-1:0]    o_mswitch,
  output logic [NSLAVES*MIDX_W-1:0] o_sswitch,
  output logic [NSLAVES-1:0]        o_sbusy
);

  mst_e                st_q   [NMASTERS];
  mst_e                st_d   [NMASTERS];
  logic [PW-1:0]       port_q [NMASTERS];
  logic [PW-1:0]       port_d [NMASTERS];
  logic [PW-1:0]       eff    [NMASTERS];
  logic [NMASTERS-1:0] newreq;
  logic [NMASTERS-1:0] errreq;
  logic [NMASTERS-1:0] gnt;
  logic [NMASTERS-1:0] req    [NSLAVES];
  logic [NMASTERS-1:0] sgnt   [NSLAVES];
  logic [MIDX_W-1:0]   sidx   [NSLAVES];
  logic [MIDX_W-1:0]   owner  [NSLAVES];
  logic [NSLAVES-1:0]  owned;

  always_comb begin
    for (int m = 0; m < NMASTERS; m++) begin
      newreq[m] = (st_q[m] == ST_IDLE) && i_act[m];
      eff[m]    = newreq[m] ? i_portno[m*PW +: PW]
                            : port_q[m];
      errreq[m] = newreq[m] &&
                  (int'(i_portno[m*PW +: PW]) >= NSLAVES);
    end
  end

  // Only a slave free at the start of the cycle takes requests, so a
  // release and a new grant never share a cycle.
  always_comb begin
    for (int s = 0; s < NSLAVES; s++) begin
      owned[s] = 1'b0;
      owner[s] = '0;
      req[s]   = '0;
      for (int m = 0; m < NMASTERS; m++) begin
        if (st_q[m] == ST_OWN && int'(port_q[m]) == s) begin
          owned[s] = 1'b1;
          owner[s] = MIDX_W'(m);
        end
        req[s][m] =
          (st_q[m] == ST_WAIT && int'(port_q[m]) == s) ||
          (newreq[m] && int'(i_portno[m*PW +: PW]) == s);
      end
      if (owned[s]) req[s] = '0;
    end
  end

  for (genvar s = 0; s < NSLAVES; s++) begin : g_arb
    fabric3_arbiter #(
      .N (NMASTERS),
      .W (MIDX_W)
    ) u_arb (
      .clk   (clk),
      .nrst  (nrst),
      .req_i (req[s]),
      .gnt_o (sgnt[s]),
      .idx_o (sidx[s])
    );
  end

  always_comb begin
    gnt = errreq;
    for (int s = 0; s < NSLAVES; s++) gnt = gnt | sgnt[s];
    for (int m = 0; m < NMASTERS; m++) begin
      if (st_q[m] == ST_OWN) gnt[m] = 1'b1;
    end
  end

  always_comb begin
    for (int m = 0; m < NMASTERS; m++) begin
      st_d[m]   = st_q[m];
      port_d[m] = port_q[m];
      if (newreq[m]) port_d[m] = i_portno[m*PW +: PW];
      if (gnt[m] && i_done[m]) st_d[m] = ST_IDLE;
      else if (gnt[m])         st_d[m] = ST_OWN;
      else if (newreq[m])      st_d[m] = ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int m = 0; m < NMASTERS; m++) begin
        st_q[m]   <= ST_IDLE;
        port_q[m] <= '0;
      end
    end else begin
      for (int m = 0; m < NMASTERS; m++) begin
        st_q[m]   <= st_d[m];
        port_q[m] <= port_d[m];
      end
    end
  end

  always_comb begin
    o_grant   = nrst ? gnt : '0;
    o_mswitch = '0;
    o_sswitch = '0;
    o_sbusy   = '0;
    for (int m = 0; m < NMASTERS; m++) begin
      if (nrst) o_mswitch[m*PW +: PW] = eff[m];
    end
    for (int s = 0; s < NSLAVES; s++) begin
      if (nrst) begin
        o_sbusy[s] = owned[s] || (|sgnt[s]);
        o_sswitch[s*MIDX_W +: MIDX_W] =
          owned[s] ? owner[s] : sidx[s];
      end
    end
  end

endmodule
